// File: rtl/exc_defs.sv
// Shared definitions for the exception-entry path: vector addresses, mux selector codes,
// sequencer state encoding and cause codes.
package exc_defs;

  // Handler vector addresses in memory, selected through the address mux
  localparam logic [7:0] VEC_OPCODE   = 8'd253;
  localparam logic [7:0] VEC_OVERFLOW = 8'd254;
  localparam logic [7:0] VEC_DIV0     = 8'd255;

  // Memory-address mux selector codes
  localparam logic [3:0] SEL_IDLE     = 4'b0000;
  localparam logic [3:0] SEL_OPCODE   = 4'b0010;
  localparam logic [3:0] SEL_OVERFLOW = 4'b0011;
  localparam logic [3:0] SEL_DIV0     = 4'b0100;

  // Cause register codes
  localparam logic [1:0] CAUSE_NONE     = 2'b00;
  localparam logic [1:0] CAUSE_OPCODE   = 2'b01;
  localparam logic [1:0] CAUSE_OVERFLOW = 2'b10;
  localparam logic [1:0] CAUSE_DIV0     = 2'b11;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StSave = 2'b01,
    StWait = 2'b10,
    StLoad = 2'b11
  } exc_state_e;

  // Prioritised request select: opcode > overflow > div0
  function automatic logic [3:0] pick_sel(input logic opcode, input logic overflow,
                                          input logic div0);
    if (opcode) begin
      return SEL_OPCODE;
    end else if (overflow) begin
      return SEL_OVERFLOW;
    end else if (div0) begin
      return SEL_DIV0;
    end
    return SEL_IDLE;
  endfunction

  // Map a selector code onto its cause code
  function automatic logic [1:0] sel_to_cause(input logic [3:0] sel);
    unique case (sel)
      SEL_OPCODE:   return CAUSE_OPCODE;
      SEL_OVERFLOW: return CAUSE_OVERFLOW;
      SEL_DIV0:     return CAUSE_DIV0;
      default:      return CAUSE_NONE;
    endcase
  endfunction

endpackage

// File: rtl/exc_wait_counter.sv
// Loadable 4-bit down-counter timing the memory-read wait. done is high while the
// count is 1, i.e. during the last wait cycle.
module exc_wait_counter (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       dec,
  output logic       done
);

  logic [3:0] cnt_q;

  // Count register: load has priority, decrement saturates at zero
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= 4'd0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (dec && (cnt_q != 4'd0)) begin
      cnt_q <= cnt_q - 4'd1;
    end
  end

  // Terminal-count flag
  always_comb begin
    done = (cnt_q == 4'd1);
  end

endmodule

// File: rtl/exc_vector_loader.sv
// Exception-entry sequencer. On a request it selects the vector address, waits out the
// memory latency, writes EPC and loads PC from the low byte of memory data.
// Optional macro EXC_CAUSE_REG_EN adds a 2-bit cause output register.
module exc_vector_loader
  import exc_defs::*;
#(
  parameter int unsigned MEM_LAT    = 2,
  parameter logic [31:0] EPC_OFFSET = 32'd4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        exc_opcode,
  input  logic        exc_overflow,
  input  logic        exc_div0,
  input  logic [31:0] pc_in,
  input  logic [31:0] mem_data_in,
  output logic [3:0]  addr_sel,
  output logic        mem_wr,
`ifdef EXC_CAUSE_REG_EN
  output logic [1:0]  cause,
`endif
  output logic        busy,
  output logic        epc_write,
  output logic [31:0] epc_out,
  output logic        pc_write,
  output logic [31:0] pc_out
);

  exc_state_e  state_q, state_d;
  logic [31:0] pc_cap_q;
  logic [3:0]  code_q;
  logic        req_any;
  logic        accept;
  logic        cnt_done;
  logic        unused_mem_hi;

  assign req_any       = exc_opcode | exc_overflow | exc_div0;
  assign accept        = (state_q == StIdle) && req_any;
  assign unused_mem_hi = ^mem_data_in[31:8];

  exc_wait_counter u_wait_counter (
    .clk      (clk),
    .reset    (reset),
    .load     (state_q == StSave),
    .load_val (4'(MEM_LAT)),
    .dec      (state_q == StWait),
    .done     (cnt_done)
  );

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Capture PC and the winning selector code on the accepting edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_cap_q <= 32'd0;
      code_q   <= SEL_IDLE;
    end else if (accept) begin
      pc_cap_q <= pc_in;
      code_q   <= pick_sel(exc_opcode, exc_overflow, exc_div0);
    end
  end

`ifdef EXC_CAUSE_REG_EN
  logic [1:0] cause_q;

  // Cause holds until the next accepted exception
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cause_q <= CAUSE_NONE;
    end else if (accept) begin
      cause_q <= sel_to_cause(pick_sel(exc_opcode, exc_overflow, exc_div0));
    end
  end

  assign cause = cause_q;
`endif

  // Next-state logic; requests outside IDLE are dropped
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (req_any) state_d = StSave;
      StSave: state_d = StWait;
      StWait: if (cnt_done) state_d = StLoad;
      StLoad: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output decode from state and capture registers; pc_out also follows memory data in LOAD
  always_comb begin
    mem_wr    = 1'b0;
    busy      = 1'b0;
    addr_sel  = SEL_IDLE;
    epc_write = 1'b0;
    epc_out   = 32'd0;
    pc_write  = 1'b0;
    pc_out    = 32'd0;
    unique case (state_q)
      StSave: begin
        busy      = 1'b1;
        addr_sel  = code_q;
        epc_write = 1'b1;
        epc_out   = pc_cap_q - EPC_OFFSET;
      end
      StWait: begin
        busy     = 1'b1;
        addr_sel = code_q;
      end
      StLoad: begin
        busy     = 1'b1;
        addr_sel = code_q;
        pc_write = 1'b1;
        pc_out   = {24'd0, mem_data_in[7:0]};
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_exc_vector_loader.sv
// Directed bench for exc_vector_loader: a MEM_LAT=2 instance and a MEM_LAT=1 instance
// share stimulus; each sequence is observed cycle by cycle on the falling edge.
module tb_exc_vector_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        exc_opcode, exc_overflow, exc_div0;
  logic [31:0] pc_in, mem_data_in;
  logic [3:0]  addr_sel, addr_sel2;
  logic        mem_wr, mem_wr2, busy, busy2;
  logic        epc_write, epc_write2, pc_write, pc_write2;
  logic [31:0] epc_out, epc_out2, pc_out, pc_out2;
`ifdef EXC_CAUSE_REG_EN
  logic [1:0]  cause, cause2;
`endif

  int n_cmp = 0;
  int n_err = 0;

  // Per-sequence observations
  int          busy_cnt, busy2_cnt, pcw_cnt, epcw_cnt;
  logic [31:0] epc_seen, pc_seen;
  logic [3:0]  sel_seen;
  logic        sel_bad, zero_bad, memwr_bad;

  always #5 clk = ~clk;

  exc_vector_loader #(.MEM_LAT(2), .EPC_OFFSET(32'd4)) dut (
    .clk          (clk),
    .reset        (reset),
    .exc_opcode   (exc_opcode),
    .exc_overflow (exc_overflow),
    .exc_div0     (exc_div0),
    .pc_in        (pc_in),
    .mem_data_in  (mem_data_in),
    .addr_sel     (addr_sel),
    .mem_wr       (mem_wr),
`ifdef EXC_CAUSE_REG_EN
    .cause        (cause),
`endif
    .busy         (busy),
    .epc_write    (epc_write),
    .epc_out      (epc_out),
    .pc_write     (pc_write),
    .pc_out       (pc_out)
  );

  exc_vector_loader #(.MEM_LAT(1), .EPC_OFFSET(32'd4)) dut_lat1 (
    .clk          (clk),
    .reset        (reset),
    .exc_opcode   (exc_opcode),
    .exc_overflow (exc_overflow),
    .exc_div0     (exc_div0),
    .pc_in        (pc_in),
    .mem_data_in  (mem_data_in),
    .addr_sel     (addr_sel2),
    .mem_wr       (mem_wr2),
`ifdef EXC_CAUSE_REG_EN
    .cause        (cause2),
`endif
    .busy         (busy2),
    .epc_write    (epc_write2),
    .epc_out      (epc_out2),
    .pc_write     (pc_write2),
    .pc_out       (pc_out2)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Raise the given requests at a falling edge, drop them after acceptance, optionally pulse
  // div0 at loop step div0_at, and record what the main instance does until it is idle again.
  task automatic run_seq(input logic op, input logic ov, input logic d0, input logic [31:0] pc,
                         input logic [31:0] data, input int div0_at);
    bit finished = 1'b0;
    busy_cnt = 0; busy2_cnt = 0; pcw_cnt = 0; epcw_cnt = 0;
    epc_seen = 32'd0; pc_seen = 32'd0; sel_seen = 4'd0;
    sel_bad = 1'b0; zero_bad = 1'b0; memwr_bad = 1'b0;
    @(negedge clk);
    exc_opcode = op; exc_overflow = ov; exc_div0 = d0;
    pc_in = pc; mem_data_in = data;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (busy) begin
        if (busy_cnt == 0) sel_seen = addr_sel;
        else if (addr_sel != sel_seen) sel_bad = 1'b1;
        if (addr_sel == 4'd0) sel_bad = 1'b1;
        busy_cnt++;
      end
      if (busy2) busy2_cnt++;
      if (epc_write) begin epcw_cnt++; epc_seen = epc_out; end
      else if (epc_out != 32'd0) zero_bad = 1'b1;
      if (pc_write) begin pcw_cnt++; pc_seen = pc_out; end
      else if (pc_out != 32'd0) zero_bad = 1'b1;
      if (mem_wr || mem_wr2) memwr_bad = 1'b1;
      if (i == 0) begin exc_opcode = 1'b0; exc_overflow = 1'b0; exc_div0 = 1'b0; end
      if (i == div0_at) exc_div0 = 1'b1;
      if (i == div0_at + 1) exc_div0 = 1'b0;
      if (i > 0 && !busy && !busy2) begin
        finished = 1'b1;
        break;
      end
    end
    check_val("seq_finished", {31'd0, finished}, 32'd1);
  endtask

  task automatic check_seq(input string tag, input logic [31:0] epc, input logic [3:0] sel,
                           input logic [31:0] pcv);
    check_val({tag, "_epc"}, epc_seen, epc);
    check_val({tag, "_sel"}, {28'd0, sel_seen}, {28'd0, sel});
    check_val({tag, "_pc"}, pc_seen, pcv);
    check_val({tag, "_busy"}, busy_cnt, 32'd4);
    check_val({tag, "_busy_lat1"}, busy2_cnt, 32'd3);
    check_val({tag, "_pcw"}, pcw_cnt, 32'd1);
    check_val({tag, "_epcw"}, epcw_cnt, 32'd1);
    check_val({tag, "_sel_stable"}, {31'd0, sel_bad}, 32'd0);
    check_val({tag, "_idle_zero"}, {31'd0, zero_bad}, 32'd0);
    check_val({tag, "_mem_wr"}, {31'd0, memwr_bad}, 32'd0);
  endtask

  initial begin
    int pcw_rst;
    reset = 1'b1;
    exc_opcode = 1'b0; exc_overflow = 1'b0; exc_div0 = 1'b0;
    pc_in = 32'd0; mem_data_in = 32'd0;
    #1;
    check_val("rst_busy", {31'd0, busy}, 32'd0);
    check_val("rst_sel", {28'd0, addr_sel}, 32'd0);
    check_val("rst_strobes", {30'd0, epc_write, pc_write}, 32'd0);
    check_val("rst_epc_out", epc_out, 32'd0);
    check_val("rst_pc_out", pc_out, 32'd0);
    check_val("rst_mem_wr", {31'd0, mem_wr}, 32'd0);
`ifdef EXC_CAUSE_REG_EN
    check_val("rst_cause", {30'd0, cause}, 32'd0);
`endif
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Overflow, pc 0x40, data 0xA4: cycle-exact walk of the main instance
    @(negedge clk);
    exc_overflow = 1'b1; pc_in = 32'h40; mem_data_in = 32'hA4;
    @(negedge clk);
    exc_overflow = 1'b0;
    check_val("t1_save_busy", {31'd0, busy}, 32'd1);
    check_val("t1_save_epcw", {31'd0, epc_write}, 32'd1);
    check_val("t1_save_epc", epc_out, 32'h3C);
    check_val("t1_save_sel", {28'd0, addr_sel}, 32'h3);
    for (int w = 0; w < 2; w++) begin
      @(negedge clk);
      check_val("t1_wait_sel", {28'd0, addr_sel}, 32'h3);
      check_val("t1_wait_strobes", {30'd0, epc_write, pc_write}, 32'd0);
    end
    @(negedge clk);
    check_val("t1_load_pcw", {31'd0, pc_write}, 32'd1);
    check_val("t1_load_pc", pc_out, 32'hA4);
    @(negedge clk);
    check_val("t1_idle_busy", {31'd0, busy}, 32'd0);
    check_val("t1_idle_sel", {28'd0, addr_sel}, 32'd0);

    // Same sequence through the recorder, also covering the MEM_LAT=1 instance
    run_seq(1'b0, 1'b1, 1'b0, 32'h40, 32'hA4, -5);
    check_seq("ovf", 32'h3C, 4'h3, 32'hA4);

    // Opcode and div0 together: opcode wins, div0 dropped
    run_seq(1'b1, 1'b0, 1'b1, 32'h100, 32'h12345678, -5);
    check_seq("prio", 32'hFC, 4'h2, 32'h78);
`ifdef EXC_CAUSE_REG_EN
    check_val("prio_cause", {30'd0, cause}, 32'h1);
`endif
    repeat (3) @(negedge clk);
    check_val("prio_no_div0", {31'd0, busy}, 32'd0);

    // div0 pulsed during WAIT of an overflow sequence is ignored
    run_seq(1'b0, 1'b1, 1'b0, 32'h2000, 32'h55, 1);
    check_seq("ign", 32'h1FFC, 4'h3, 32'h55);
    repeat (3) @(negedge clk);
    check_val("ign_no_requeue", {31'd0, busy}, 32'd0);

    // Reset asserted mid-WAIT: outputs clear before any clock edge, no PC write
    @(negedge clk);
    exc_overflow = 1'b1; pc_in = 32'h40; mem_data_in = 32'hA4;
    @(negedge clk);
    exc_overflow = 1'b0;
    @(negedge clk);
    check_val("rw_in_wait", {31'd0, busy}, 32'd1);
    #2 reset = 1'b1;
    #1;
    check_val("rw_busy", {31'd0, busy}, 32'd0);
    check_val("rw_sel", {28'd0, addr_sel}, 32'd0);
    check_val("rw_outs", epc_out | pc_out, 32'd0);
    check_val("rw_busy_lat1", {31'd0, busy2}, 32'd0);
    pcw_rst = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (pc_write) pcw_rst++;
    end
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (pc_write) pcw_rst++;
    end
    check_val("rw_no_pcw", pcw_rst, 32'd0);
    run_seq(1'b0, 1'b1, 1'b0, 32'h40, 32'hA4, -5);
    check_seq("after_rst", 32'h3C, 4'h3, 32'hA4);

    // div0 at pc 0: EPC wraps, upper data bits ignored
    run_seq(1'b0, 1'b0, 1'b1, 32'h0, 32'hFFFFFF80, -5);
    check_seq("div0", 32'hFFFFFFFC, 4'h4, 32'h80);
`ifdef EXC_CAUSE_REG_EN
    check_val("div0_cause", {30'd0, cause}, 32'h3);
    check_val("div0_cause_lat1", {30'd0, cause2}, 32'h3);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/exc_vector_loader.md
Name: exc_vector_loader

Overview:
Exception-entry sequencer on the memory-read side of the exception path. On an exception request it drives the memory-address mux selector to the matching vector code. It waits out the memory read latency and takes the handler byte from memory data-out. It then writes EPC and loads PC, while the main control FSM holds off and yields the mux selector and PC/EPC writes while busy=1.

Parameters:
MEM_LAT, 2, memory read latency in cycles from address stable to mem_data_in valid (legal 1..15)
EPC_OFFSET, 4, value subtracted from captured PC to form EPC

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
exc_opcode  input  1  nonexistent-opcode request (level, sampled in IDLE)
exc_overflow  input  1  arithmetic overflow request
exc_div0  input  1  divide-by-zero request
pc_in  input  32  current PC value
mem_data_in  input  32  memory read data
addr_sel  output  4  selector to memory-address mux: 0000 idle/PC, 0010 opcode vector (253), 0011 overflow vector (254), 0100 div0 vector (255)
mem_wr  output  1  memory write enable, constant 0
busy  output  1  sequencer owns mux selector, PC and EPC writes
epc_write  output  1  EPC register write strobe
epc_out  output  32  EPC write data
pc_write  output  1  PC register write strobe
pc_out  output  32  PC write data

Behaviour:
- Reset: async, active-high. State=IDLE. addr_sel=0000, busy=0, epc_write=0, pc_write=0, epc_out=0, pc_out=0, mem_wr=0, counters and capture regs=0.
- States: IDLE -> SAVE -> WAIT -> LOAD -> IDLE. Registered state; outputs decoded from state and capture regs (Moore), except pc_out in LOAD.
- IDLE: any request high at a rising edge -> SAVE. Same edge captures pc_in and the selected code.
- Priority on simultaneous requests: opcode > overflow > div0; the lower ones are dropped.
- SAVE (1 cycle): busy=1, addr_sel=code, epc_write=1, epc_out=captured_pc - EPC_OFFSET. Mod 2^32, so 0 wraps to 0xFFFFFFFC.
- WAIT (exactly MEM_LAT cycles): busy=1, addr_sel held, all write strobes 0. A 4-bit down-counter is loaded at SAVE; leave when it reaches 1.
- LOAD (1 cycle): busy=1, addr_sel held, pc_write=1, pc_out={24'b0, mem_data_in[7:0]}. Upper data bits are ignored. Next state IDLE.
- busy is high for exactly MEM_LAT+2 cycles per exception. addr_sel is non-zero throughout busy, including SAVE.
- Requests while not IDLE: ignored, not queued.
- A request still high when returning to IDLE is re-accepted on the next edge. The control FSM must deassert it.
- Reset mid-operation: immediate return to reset values. No pc_write is issued; a partial EPC write is not undone.
- epc_out and pc_out read 0 when their strobe is low.

Optional Feature:
EXC_CAUSE_REG_EN
- Defined: adds output cause[1:0] (01 opcode, 10 overflow, 11 div0). It loads at the SAVE-entry edge, holds until the next accepted exception, and resets to 00.
- Undefined: no cause port, no register.

Decomposition:
- Shared package/include exc_defs: vector addresses 253/254/255, selector codes 0000/0010/0011/0100, state encodings, cause codes.
- Sub-module exc_wait_counter: loadable 4-bit down-counter with `done` flag, instantiated once for WAIT.

Test Plan:
- Overflow, pc_in=0x00000040, MEM_LAT=2, mem_data_in=0x000000A4:
  - SAVE: epc_write with 0x0000003C, addr_sel=0011.
  - 2 WAIT cycles with addr_sel=0011.
  - LOAD: pc_write with pc_out=0x000000A4.
  - busy high for 4 cycles.
- exc_opcode and exc_div0 asserted on the same edge -> addr_sel=0010 for the whole sequence; div0 never serviced (cause=01 if EN).
- exc_div0 pulsed during WAIT of an overflow sequence -> ignored, one pc_write only, addr_sel stays 0011.
- reset asserted mid-WAIT -> all outputs to reset values without waiting for a clock edge, no pc_write; a new overflow after release runs normally.
- pc_in=0x00000000, div0, mem_data_in=0xFFFFFF80 -> epc_out=0xFFFFFFFC, addr_sel=0100, pc_out=0x00000080.
- MEM_LAT=1 build -> busy exactly 3 cycles, a single WAIT cycle.
